rtc_set_ctrl: RTL and testbench
===============================

# rtc_set_ctrl

Button-driven time-setting controller for the BCD hh:mm:ss real-time clock. It runs on the 100 Hz hundred_clk. It debounces two push-buttons, freezes the timekeeper while the user edits the hour, minute and second fields in sequence, and commits the edited time with a single-cycle load strobe. It sits between the board buttons and the timekeeper counters, and drives the field-blink mask for the display.

## Interface
Parameters:
- DEBOUNCE_TICKS, 3, consecutive stable samples needed to accept a button level (30 ms).
- TIMEOUT_TICKS, 3000, idle ticks in any SET state before the edit is aborted (30 s).
- REPEAT_DELAY, 50, hold ticks before auto-repeat starts (500 ms).
- REPEAT_RATE, 10, ticks between auto-repeat increments (100 ms).

Ports:
- hundred_clk  in  1  100 Hz clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- btn_mode  in  1  raw mode button, asynchronous, high = pressed.
- btn_inc  in  1  raw increment button, asynchronous, high = pressed.
- cur_time  in  24  live BCD time {hrm,hrl,minm,minl,secm,secl}, 4 bits per digit.
- set_time  out  24  edited BCD time, same packing; valid while load=1.
- load  out  1  one-cycle strobe; the timekeeper loads set_time on this edge.
- run_en  out  1  timekeeper count enable; 0 while editing.
- blink_mask  out  3  {hour,min,sec}; 1 = blank that field this cycle.
- mode_state  out  2  current FSM state encoding, for debug.

## Operation
- Button path, per button: 2-flop synchronizer, then a debounce counter. The level is accepted after DEBOUNCE_TICKS identical samples. A press event is the accepted 0->1 edge.
- FSM states: RUN(0), SET_HR(1), SET_MIN(2), SET_SEC(3).
- RUN, mode press: capture cur_time into the edit register, go to SET_HR, run_en=0.
- SET_HR, mode press: go to SET_MIN.
- SET_MIN, mode press: go to SET_SEC.
- SET_SEC, mode press: go to RUN, load=1 for that one cycle, run_en=1.
- Increment press in SET_x: BCD-increment the active field.
  - Hours 00..23, with 23 wrapping to 00.
  - Minutes and seconds 00..59, with 59 wrapping to 00.
  - The low digit wraps 9->0 and carries into the high digit. No carry crosses into the next field.
- Increment press in RUN is ignored.
- Mode and increment presses in the same cycle: mode wins, the increment is discarded.
- Timeout: an idle counter clears on any press event. When it reaches TIMEOUT_TICKS in a SET state, go to RUN with load=0 and run_en=1, and discard the edit.
- set_time is driven from the edit register at all times, and is meaningful only when load=1.
- Blink: a 50-tick phase counter; phase=1 for ticks 25..49. The blink_mask bit of the active field equals phase. The other bits are 0. In RUN, blink_mask=000.
- Reset value of every output: set_time=0, load=0, run_en=1, blink_mask=000, mode_state=RUN.
- Reset mid-edit forces RUN, discards the edit, and never emits load.

## Timing
- Press latency: a press event is recognized 2+DEBOUNCE_TICKS cycles after a clean raw edge.
- The state change and field update take effect on the edge after the press event.
- load and run_en=1 assert in the same cycle, so the timekeeper resumes counting from set_time on the next edge.
- cur_time is sampled on the edge that leaves RUN.
- run_en falls in the cycle after the mode press event.

## Configuration
- RTC_AUTOREPEAT_EN defined:
  - Holding btn_inc for REPEAT_DELAY ticks after its press event adds one increment.
  - Further increments follow every REPEAT_RATE ticks while the button is held.
  - Each repeat increment also clears the idle counter.
- RTC_AUTOREPEAT_EN undefined: exactly one increment per press. The repeat counters and parameters are unused and optimized away.

## Structure
- Package rtc_pkg holds:
  - the state enum;
  - HR_MAX_BCD=8'h23 and MIN_SEC_MAX_BCD=8'h59;
  - field index constants FLD_HR/FLD_MIN/FLD_SEC;
  - the 24-bit time bit-slice localparams.
- Sub-module rtc_btn_debounce: synchronizer, debounce, edge detect and optional repeat. It outputs a press pulse and is instantiated twice.
- The BCD field increment is a function in rtc_pkg.

## Test plan
- Reset mid-edit: reach SET_MIN, then assert rst -> all outputs at reset values, mode_state=0, load stays 0.
- Full edit: cur_time=12:34:56; mode; inc ×2; mode; inc; mode; mode -> one load pulse with set_time=24'h143556, and run_en=1 in the same cycle.
- Field wrap: hours=23, one inc -> 00. Minutes=59, one inc -> 00 with the hour field unchanged. Seconds=09, one inc -> 10.
- Bounce rejection: btn_inc toggling every tick for 20 ticks, then held low -> no increment. Held high for 2 ticks only -> no press.
- Timeout and simultaneous presses:
  - Enter SET_HR and stay idle 3000 ticks -> RUN, load=0, run_en=1.
  - Mode and inc pressed together in SET_HR -> SET_MIN, hour unchanged.
- Auto-repeat (macro on): hold inc for 100 ticks in SET_MIN from 00 -> minutes=06 (1 press, plus 1 at tick 50, plus 4 at ticks 60..90). With the macro off, the same stimulus gives 01.

Source files
------------

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared states, BCD limits, time field slices and field increment for rtc_set_ctrl
package rtc_pkg;
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } rtc_state_e;

  localparam logic [7:0] HR_MAX_BCD      = 8'h23;
  localparam logic [7:0] MIN_SEC_MAX_BCD = 8'h59;

  localparam int FLD_HR  = 2;
  localparam int FLD_MIN = 1;
  localparam int FLD_SEC = 0;

  localparam int FLD_W   = 8;
  localparam int HR_LSB  = 16;
  localparam int MIN_LSB = 8;
  localparam int SEC_LSB = 0;

  // Two-digit BCD increment; wraps to 00 after max and never carries out of the field.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    return v == max ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
endpackage

// File: rtl/rtc_set_ctrl_if.sv
// rtc_set_ctrl_if: button, live-time and timekeeper/display signals of the time-setting controller
interface rtc_set_ctrl_if;
  logic        btn_mode;
  logic        btn_inc;
  logic [23:0] cur_time;
  logic [23:0] set_time;
  logic        load;
  logic        run_en;
  logic [2:0]  blink_mask;
  logic [1:0]  mode_state;

  modport master (
    output btn_mode, btn_inc, cur_time,
    input  set_time, load, run_en, blink_mask, mode_state
  );

  modport slave (
    input  btn_mode, btn_inc, cur_time,
    output set_time, load, run_en, blink_mask, mode_state
  );
endinterface

// File: rtl/rtc_btn_debounce.sv
// rtc_btn_debounce: 2-flop sync, debounce, press pulse; auto-repeat when RTC_AUTOREPEAT_EN is defined
module rtc_btn_debounce #(
  parameter int DEBOUNCE_TICKS = 3,
  parameter int REPEAT_EN      = 0,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10
) (
  input  logic hundred_clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             press_q, press_d;
  logic             diff, accept, rise;

  assign diff   = sync_q[1] != lvl_q;
  assign accept = diff && cnt_q == CNT_W'(DEBOUNCE_TICKS - 1);
  assign rise   = lvl_d & ~lvl_q;
  assign press  = press_q;

  always_comb begin
    sync_d = {sync_q[0], btn};
    cnt_d  = diff && !accept ? cnt_q + 1'b1 : '0;
    lvl_d  = accept ? sync_q[1] : lvl_q;
  end

`ifdef RTC_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY + 1);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_fire;

  // Only fire while the accepted level stays high through this edge, so a release cancels it.
  assign rep_fire = REPEAT_EN != 0 && lvl_q && lvl_d && rep_q == REP_W'(REPEAT_DELAY - 1);

  always_comb begin
    rep_d   = rise ? '0 : rep_fire ? REP_W'(REPEAT_DELAY - REPEAT_RATE) : lvl_q ? rep_q + 1'b1 : rep_q;
    press_d = rise | rep_fire;
  end

  always_ff @(posedge hundred_clk or posedge rst)
    if (rst) rep_q <= '0;
    else     rep_q <= rep_d;
`else
  logic unused_rep;
  assign unused_rep = |{REPEAT_EN, REPEAT_DELAY, REPEAT_RATE};
  assign press_d    = rise;
`endif

  always_ff @(posedge hundred_clk or posedge rst)
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
    end
endmodule

// File: rtl/rtc_set_ctrl.sv
// rtc_set_ctrl: button-driven hh:mm:ss edit FSM with load strobe and field blink.
// Define RTC_AUTOREPEAT_EN to enable auto-repeat on the increment button.
module rtc_set_ctrl
  import rtc_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 3,
  parameter int TIMEOUT_TICKS  = 3000,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10
) (
  input logic            hundred_clk,
  input logic            rst,
  rtc_set_ctrl_if.slave  bus
);
  localparam int IDLE_W = $clog2(TIMEOUT_TICKS + 1);

  rtc_state_e        state_q, state_d;
  logic [23:0]       edit_q, edit_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [5:0]        phase_q, phase_d;
  logic              load_q, load_d;
  logic              mode_p, inc_p, phase;
  logic [4:0]        lsb;
  logic [7:0]        fld_max;
  logic [2:0]        blink;

  rtc_btn_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS), .REPEAT_EN(0),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) u_mode (
    .hundred_clk(hundred_clk), .rst(rst), .btn(bus.btn_mode), .press(mode_p)
  );

  rtc_btn_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS), .REPEAT_EN(1),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) u_inc (
    .hundred_clk(hundred_clk), .rst(rst), .btn(bus.btn_inc), .press(inc_p)
  );

  assign lsb     = state_q == SET_HR ? 5'(HR_LSB) : state_q == SET_MIN ? 5'(MIN_LSB) : 5'(SEC_LSB);
  assign fld_max = state_q == SET_HR ? HR_MAX_BCD : MIN_SEC_MAX_BCD;
  assign phase   = phase_q >= 6'd25;

  always_comb begin
    blink          = '0;
    blink[FLD_HR]  = phase && state_q == SET_HR;
    blink[FLD_MIN] = phase && state_q == SET_MIN;
    blink[FLD_SEC] = phase && state_q == SET_SEC;
  end

  assign bus.set_time   = edit_q;
  assign bus.load       = load_q;
  assign bus.run_en     = state_q == RUN;
  assign bus.blink_mask = blink;
  assign bus.mode_state = state_q;

  // Mode outranks increment; SET_SEC + 1 wraps to RUN and raises load alongside run_en.
  always_comb begin
    state_d = state_q;
    edit_d  = edit_q;
    load_d  = 1'b0;
    idle_d  = state_q == RUN || mode_p || inc_p ? '0 : idle_q + 1'b1;
    phase_d = phase_q == 6'd49 ? '0 : phase_q + 6'd1;
    if (state_q == RUN) begin
      if (mode_p) begin
        state_d = SET_HR;
        edit_d  = bus.cur_time;
      end
    end else if (mode_p) begin
      state_d = rtc_state_e'(state_q + 2'd1);
      load_d  = state_q == SET_SEC;
    end else if (inc_p)
      edit_d[lsb +: FLD_W] = bcd_inc(edit_q[lsb +: FLD_W], fld_max);
    else if (idle_q == IDLE_W'(TIMEOUT_TICKS - 1))
      state_d = RUN;
  end

  always_ff @(posedge hundred_clk or posedge rst)
    if (rst) begin
      state_q <= RUN;
      edit_q  <= '0;
      idle_q  <= '0;
      phase_q <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      edit_q  <= edit_d;
      idle_q  <= idle_d;
      phase_q <= phase_d;
      load_q  <= load_d;
    end
endmodule

// File: tb/tb_rtc_set_ctrl.sv
// tb_rtc_set_ctrl: directed bench for rtc_set_ctrl; expectations follow RTC_AUTOREPEAT_EN
module tb_rtc_set_ctrl;
  logic hundred_clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  int base;
  logic [23:0] load_time = '0;
  logic load_run = 1'b0;

  rtc_set_ctrl_if bus();

  rtc_set_ctrl dut (.hundred_clk(hundred_clk), .rst(rst), .bus(bus));

  always #5 hundred_clk = ~hundred_clk;

  always @(negedge hundred_clk)
    if (bus.load) begin
      load_cnt++;
      load_time = bus.set_time;
      load_run  = bus.run_en;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge hundred_clk);
  endtask

  task automatic push(input logic m, input logic i, input int hold);
    @(negedge hundred_clk);
    bus.btn_mode = m;
    bus.btn_inc  = i;
    ticks(hold);
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    ticks(10);
  endtask

  task automatic blink_chk(input logic [2:0] exp);
    logic [2:0] or_m = '0;
    int on = 0;
    repeat (50) begin
      @(negedge hundred_clk);
      or_m |= bus.blink_mask;
      if (bus.blink_mask != 3'b000) on++;
    end
    chk("blink_field", 32'(or_m), 32'(exp));
    chk("blink_on_ticks", on, 25);
  endtask

  initial begin
    int n;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.cur_time = 24'h123456;
    ticks(3);
    chk("rst_set_time", 32'(bus.set_time), 0);
    chk("rst_load", 32'(bus.load), 0);
    chk("rst_run_en", 32'(bus.run_en), 1);
    chk("rst_blink", 32'(bus.blink_mask), 0);
    chk("rst_state", 32'(bus.mode_state), 0);
    rst = 1'b0;
    ticks(5);

    base = load_cnt;
    push(1, 0, 8);
    chk("edit_state_hr", 32'(bus.mode_state), 1);
    chk("edit_run_en", 32'(bus.run_en), 0);
    chk("edit_capture", 32'(bus.set_time), 32'h123456);
    blink_chk(3'b100);
    push(0, 1, 8);
    push(0, 1, 8);
    chk("edit_hr_inc2", 32'(bus.set_time), 32'h143456);
    push(1, 0, 8);
    chk("edit_state_min", 32'(bus.mode_state), 2);
    push(0, 1, 8);
    chk("edit_min_inc", 32'(bus.set_time), 32'h143556);
    push(1, 0, 8);
    chk("edit_state_sec", 32'(bus.mode_state), 3);
    push(1, 0, 8);
    chk("edit_load_cnt", load_cnt - base, 1);
    chk("edit_load_time", 32'(load_time), 32'h143556);
    chk("edit_load_run", 32'(load_run), 1);
    chk("edit_back_run", 32'(bus.mode_state), 0);

    base = load_cnt;
    push(1, 0, 8);
    push(1, 0, 8);
    chk("rstmid_state_min", 32'(bus.mode_state), 2);
    blink_chk(3'b010);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_state", 32'(bus.mode_state), 0);
    chk("rstmid_run_en", 32'(bus.run_en), 1);
    chk("rstmid_load", 32'(bus.load), 0);
    chk("rstmid_set_time", 32'(bus.set_time), 0);
    chk("rstmid_blink", 32'(bus.blink_mask), 0);
    ticks(3);
    rst = 1'b0;
    ticks(20);
    chk("rstmid_no_load", load_cnt - base, 0);

    bus.cur_time = 24'h235909;
    push(1, 0, 8);
    push(0, 1, 8);
    chk("wrap_hr", 32'(bus.set_time), 32'h005909);
    push(1, 0, 8);
    push(0, 1, 8);
    chk("wrap_min", 32'(bus.set_time), 32'h000009);
    push(1, 0, 8);
    push(0, 1, 8);
    chk("wrap_sec", 32'(bus.set_time), 32'h000010);
    base = load_cnt;
    push(1, 0, 8);
    chk("wrap_load_cnt", load_cnt - base, 1);
    chk("wrap_load_time", 32'(load_time), 32'h000010);

    bus.cur_time = 24'h000000;
    push(1, 0, 8);
    for (int i = 0; i < 20; i++) begin
      bus.btn_inc = ~bus.btn_inc;
      ticks(1);
    end
    bus.btn_inc = 1'b0;
    ticks(15);
    chk("bounce_toggle", 32'(bus.set_time), 0);
    bus.btn_inc = 1'b1;
    ticks(2);
    bus.btn_inc = 1'b0;
    ticks(15);
    chk("bounce_short", 32'(bus.set_time), 0);
    chk("bounce_state", 32'(bus.mode_state), 1);

    push(1, 1, 8);
    chk("simul_state", 32'(bus.mode_state), 2);
    chk("simul_hr_kept", 32'(bus.set_time), 0);
    push(1, 0, 8);
    push(1, 0, 8);
    chk("simul_back_run", 32'(bus.mode_state), 0);

    base = load_cnt;
    push(1, 0, 8);
    push(0, 1, 8);
    chk("tmo_edit", 32'(bus.set_time), 32'h010000);
    ticks(2950);
    chk("tmo_not_yet", 32'(bus.mode_state), 1);
    n = 0;
    while (bus.mode_state != 2'd0 && n < 100) begin
      ticks(1);
      n++;
    end
    chk("tmo_reached", 32'(n < 100), 1);
    chk("tmo_no_load", load_cnt - base, 0);
    chk("tmo_run_en", 32'(bus.run_en), 1);
    chk("tmo_blink", 32'(bus.blink_mask), 0);
    push(0, 1, 8);
    chk("run_inc_ignored", 32'(bus.set_time), 32'h010000);
    chk("run_inc_state", 32'(bus.mode_state), 0);

    push(1, 0, 8);
    push(1, 0, 8);
    push(0, 1, 100);
`ifdef RTC_AUTOREPEAT_EN
    chk("repeat_min", 32'(bus.set_time), 32'h000600);
`else
    chk("repeat_min", 32'(bus.set_time), 32'h000100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
